// File: rtl/shift_pkg.sv
// ---------------------------------------------------------------------------
// shift_pkg
//   Shared definitions for the sequential shift unit.
//   - MODE_* : operation encodings on the 2-bit mode port
//   - state_t: control FSM states (IDLE accepts, SHIFT runs stages, DONE holds)
// ---------------------------------------------------------------------------
package shift_pkg;

  localparam logic [1:0] MODE_SHL = 2'd0;
  localparam logic [1:0] MODE_SHR = 2'd1;
  localparam logic [1:0] MODE_SAR = 2'd2;
  localparam logic [1:0] MODE_ROL = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_stage.sv
// ---------------------------------------------------------------------------
// shift_stage
//   One log-shifter stage, purely combinational. Shifts i_data by 2^i_k
//   according to i_mode when i_en is set, otherwise passes it through.
//   Ports:
//     i_data  [WIDTH-1:0]  data entering the stage
//     i_mode  [1:0]        SHL / SHR / SAR / ROL
//     i_k     [KW-1:0]     stage index (shift distance is 2^i_k)
//     i_en                 shift-amount bit for this stage
//     i_sign               sign bit latched from the original operand (SAR fill)
//     o_data  [WIDTH-1:0]  stage result
// ---------------------------------------------------------------------------
module shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LOGW  = $clog2(WIDTH),
  parameter int KW    = (LOGW > 1) ? $clog2(LOGW) : 1
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic [1:0]       i_mode,
  input  logic [KW-1:0]    i_k,
  input  logic             i_en,
  input  logic             i_sign,
  output logic [WIDTH-1:0] o_data
);

  logic [LOGW:0]      w_amt;
  logic [LOGW:0]      w_ramt;
  logic [WIDTH-1:0]   w_fill;
  logic [WIDTH-1:0]   w_shifted;

  // Distance is at most WIDTH/2, so the rotate's complementary distance
  // never reaches zero or WIDTH.
  assign w_amt  = (LOGW+1)'(1) << i_k;
  assign w_ramt = (LOGW+1)'(WIDTH) - w_amt;

  // Top w_amt bits set when the operand is negative.
  assign w_fill = i_sign ? ~({WIDTH{1'b1}} >> w_amt) : '0;

  always_comb begin
    w_shifted = i_data;
    case (i_mode)
      MODE_SHL: w_shifted = i_data << w_amt;
      MODE_SHR: w_shifted = i_data >> w_amt;
      MODE_SAR: w_shifted = (i_data >> w_amt) | w_fill;
      MODE_ROL: w_shifted = (i_data << w_amt) | (i_data >> w_ramt);
      default:  w_shifted = i_data;
    endcase
  end

  assign o_data = i_en ? w_shifted : i_data;

endmodule

// File: rtl/shift_seq_unit.sv
// ---------------------------------------------------------------------------
// shift_seq_unit
//   Multi-cycle shifter: one shared shift_stage applied once per clock,
//   LOGW cycles per operation regardless of amount. Request side is a
//   valid/ready port accepted only in IDLE; the result is held on the
//   output port until the consumer takes it.
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     in_valid/in_ready   request handshake (in_ready high only in IDLE)
//     mode [1:0]          0 SHL, 1 SHR, 2 SAR, 3 ROL
//     n    [SHW-1:0]      shift amount (WIDTH itself is representable)
//     in   [WIDTH-1:0]    operand
//     out_valid/out_ready result handshake
//     out  [WIDTH-1:0]    result
//     zero                out == 0
// ---------------------------------------------------------------------------
module shift_seq_unit
  import shift_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int LOGW  = $clog2(WIDTH),
  localparam int SHW   = LOGW + 1,
  localparam int KW    = (LOGW > 1) ? $clog2(LOGW) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [SHW-1:0]   n,
  input  logic [WIDTH-1:0] in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero
);

  state_t             r_state;
  state_t             w_state_next;
  logic [1:0]         r_mode;
  logic [LOGW-1:0]    r_amt;
  logic               r_sign;
  logic [KW-1:0]      r_k;
  logic [WIDTH-1:0]   r_data;

  logic               w_accept;
  logic               w_last_stage;
  logic               w_overflow;
  logic [WIDTH-1:0]   w_latch_data;
  logic [WIDTH-1:0]   w_stage_out;

  assign w_accept     = (r_state == ST_IDLE) && in_valid;
  assign w_last_stage = (r_k == KW'(LOGW - 1));
  assign w_overflow   = |n[SHW-1:LOGW];

  // Out-of-range amounts are settled here: the data register starts at the
  // final fill value, and every later stage maps that value onto itself, so
  // the stage sequence can run unchanged and latency stays fixed. ROL needs
  // no special case because only n mod WIDTH is kept in r_amt.
  always_comb begin
    w_latch_data = in;
    if (w_overflow) begin
      case (mode)
        MODE_SHL, MODE_SHR: w_latch_data = '0;
        MODE_SAR:           w_latch_data = {WIDTH{in[WIDTH-1]}};
        default:            w_latch_data = in;
      endcase
    end
  end

  shift_stage #(
    .WIDTH (WIDTH),
    .LOGW  (LOGW),
    .KW    (KW)
  ) u_stage (
    .i_data (r_data),
    .i_mode (r_mode),
    .i_k    (r_k),
    .i_en   (r_amt[r_k]),
    .i_sign (r_sign),
    .o_data (w_stage_out)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and handshake outputs.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_last_stage) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Operand/amount capture and per-stage data update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode <= MODE_SHL;
      r_amt  <= '0;
      r_sign <= 1'b0;
      r_k    <= '0;
      r_data <= '0;
    end else begin
      if (w_accept) begin
        r_mode <= mode;
        r_amt  <= n[LOGW-1:0];
        r_sign <= in[WIDTH-1];
        r_k    <= '0;
        r_data <= w_latch_data;
      end else if (r_state == ST_SHIFT) begin
        r_data <= w_stage_out;
        r_k    <= w_last_stage ? '0 : r_k + KW'(1);
      end
    end
  end

  // r_data only changes in IDLE (on accept) and SHIFT, so it is frozen for
  // the whole DONE state, including under backpressure.
  assign out  = r_data;
  assign zero = (r_data == '0);

endmodule

// File: tb/tb_shift_seq_unit.sv
// ---------------------------------------------------------------------------
// tb_shift_seq_unit
//   Bench for shift_seq_unit: a WIDTH=32 instance tracked cycle by cycle
//   against an arithmetic reference, plus a small WIDTH=8 instance driven
//   directly.
// ---------------------------------------------------------------------------
module tb_shift_seq_unit;
  import shift_pkg::*;

  localparam int W  = 32;
  localparam int LW = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  mode = 2'd0;
  logic [5:0]  n = 6'd0;
  logic [31:0] din = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] dout;
  logic        zero;

  // 8-bit instance
  logic        b_in_valid = 1'b0;
  logic        b_in_ready;
  logic [1:0]  b_mode = 2'd0;
  logic [3:0]  b_n = 4'd0;
  logic [7:0]  b_din = 8'd0;
  logic        b_out_valid;
  logic        b_out_ready = 1'b0;
  logic [7:0]  b_dout;
  logic        b_zero;

  shift_seq_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .n         (n),
    .in        (din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (dout),
    .zero      (zero)
  );

  shift_seq_unit #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .mode      (b_mode),
    .n         (b_n),
    .in        (b_din),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out       (b_dout),
    .zero      (b_zero)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: the shift expressed directly as arithmetic on the whole
  // amount, with no notion of stages.
  function automatic logic [31:0] model(input int w, input logic [1:0] m,
                                        input int nn, input logic [31:0] x);
    logic [63:0] mask, xv, r;
    logic        s;
    int          rr;
    mask = (64'd1 << w) - 64'd1;
    xv   = {32'd0, x} & mask;
    s    = xv[w-1];
    r    = 64'd0;
    case (m)
      MODE_SHL: r = (nn >= w) ? 64'd0 : ((xv << nn) & mask);
      MODE_SHR: r = (nn >= w) ? 64'd0 : (xv >> nn);
      MODE_SAR: begin
        if (nn >= w) r = s ? mask : 64'd0;
        else         r = (xv >> nn) | (s ? (mask & ~(mask >> nn)) : 64'd0);
      end
      default: begin
        rr = nn % w;
        r  = (rr == 0) ? xv : (((xv << rr) | (xv >> (w - rr))) & mask);
      end
    endcase
    return r[31:0];
  endfunction

  typedef struct {
    logic [31:0] res;
    int          acc;
    logic [1:0]  m;
    logic [5:0]  nn;
    logic [31:0] x;
  } txn_t;

  txn_t        q[$];
  int          cyc = 0;
  int          xfer_cnt = 0;
  logic [31:0] last_out = 32'd0;
  logic        last_zero = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Cycle-level compare for the 32-bit instance.
  always @(negedge clk) begin : monitor
    logic busy, exp_ov;
    txn_t t;
    if (!rst_n) begin
      q.delete();
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out", 64'(dout), 64'd0);
      chk("rst_zero", 64'(zero), 64'd1);
    end else begin
      busy   = (q.size() != 0);
      exp_ov = busy && ((cyc - q[0].acc) >= LW);
      chk("in_ready", 64'(in_ready), 64'(!busy));
      chk("out_valid", 64'(out_valid), 64'(exp_ov));
      if (exp_ov && out_valid) begin
        chk("out", 64'(dout), 64'(q[0].res));
        chk("zero", 64'(zero), 64'(q[0].res == 32'd0));
        if (out_ready) begin
          $display("xfer mode=%0d n=%0d in=%08h out=%08h zero=%0b",
                   q[0].m, q[0].nn, q[0].x, dout, zero);
          last_out  = dout;
          last_zero = zero;
          xfer_cnt++;
          void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        t.res = model(W, mode, int'(n), din);
        t.acc = cyc + 1;
        t.m   = mode;
        t.nn  = n;
        t.x   = din;
        q.push_back(t);
      end
    end
  end

  // pol: 0 = out_ready always high, 1 = random out_ready,
  //      2 = hold out_ready low for 10 cycles of out_valid.
  // While out_ready is low (pol 1/2) in_valid is pulsed with junk.
  task automatic issue(input logic [1:0] m, input logic [5:0] nn, input logic [31:0] x,
                       input int pol, output logic [31:0] r, output logic z);
    int guard, start, hold;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) chk("issue_wait_timeout", 64'd0, 64'd1);
    in_valid  = 1'b1;
    mode      = m;
    n         = nn;
    din       = x;
    out_ready = (pol == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    mode     = 2'($urandom);
    n        = 6'($urandom);
    din      = $urandom;
    start = xfer_cnt;
    guard = 0;
    hold  = 0;
    while (xfer_cnt == start && guard < 200) begin
      case (pol)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: begin
          if (out_valid) hold++;
          out_ready = (hold > 10);
        end
      endcase
      in_valid = (pol != 0) && !out_ready && ($urandom_range(0, 1) == 1);
      @(posedge clk); #1;
      guard++;
    end
    if (xfer_cnt == start) chk("xfer_timeout", 64'd0, 64'd1);
    if (pol == 2) chk("bp_in_ready_after_release", 64'(in_ready), 64'd1);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    r = last_out;
    z = last_zero;
  endtask

  task automatic run8(input logic [1:0] m, input logic [3:0] nn, input logic [7:0] x,
                      input logic [7:0] exp);
    int lat;
    b_in_valid = 1'b1;
    b_mode     = m;
    b_n        = nn;
    b_din      = x;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    b_din      = 8'h5A;
    b_n        = 4'hF;
    lat = 0;
    while (!b_out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("w8_latency", 64'(lat), 64'd3);
    chk("w8_out", 64'(b_dout), 64'(exp));
    chk("w8_zero", 64'(b_zero), 64'(exp == 8'd0));
    $display("w8 mode=%0d n=%0d in=%02h out=%02h", m, nn, x, b_dout);
    b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_out_ready = 1'b0;
    chk("w8_in_ready", 64'(b_in_ready), 64'd1);
  endtask

  int          sweep_n [10] = '{0, 1, 2, 3, 4, 15, 25, 30, 31, 32};
  logic [31:0] sweep_e [10] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFC, 32'hFFFFFFF8,
                                32'hFFFFFFF0, 32'hFFFF8000, 32'hFE000000, 32'hC0000000,
                                32'h80000000, 32'h00000000};
  logic [1:0]  dir_m [7] = '{MODE_SHR, MODE_SAR, MODE_SAR, MODE_SHR,
                             MODE_ROL, MODE_ROL, MODE_ROL};
  logic [5:0]  dir_n [7] = '{6'd31, 6'd31, 6'd40, 6'd40, 6'd8, 6'd32, 6'd36};
  logic [31:0] dir_x [7] = '{32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000,
                             32'h12345678, 32'h12345678, 32'h12345678};
  logic [31:0] dir_e [7] = '{32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000,
                             32'h34567812, 32'h12345678, 32'h23456781};

  logic [31:0] res_v;
  logic        zero_v;

  initial begin : stim
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      issue(MODE_SHL, 6'(sweep_n[i]), 32'hFFFFFFFF, 0, res_v, zero_v);
      chk("shl_sweep", 64'(res_v), 64'(sweep_e[i]));
      chk("shl_sweep_zero", 64'(zero_v), 64'(i == 9));
    end

    for (int i = 0; i < 7; i++) begin
      issue(dir_m[i], dir_n[i], dir_x[i], 0, res_v, zero_v);
      chk("directed", 64'(res_v), 64'(dir_e[i]));
    end

    // Backpressure with junk in_valid pulses throughout SHIFT and DONE.
    issue(MODE_SAR, 6'd4, 32'h80001234, 2, res_v, zero_v);
    chk("backpressure", 64'(res_v), 64'hF8000123);

    // Reset during the second SHIFT cycle.
    in_valid = 1'b1;
    mode     = MODE_SHL;
    n        = 6'd3;
    din      = 32'h00000001;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_in_ready", 64'(in_ready), 64'd1);
    chk("async_rst_out_valid", 64'(out_valid), 64'd0);
    chk("async_rst_out", 64'(dout), 64'd0);
    chk("async_rst_zero", 64'(zero), 64'd1);
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("no_out_valid_after_rst", 64'(out_valid), 64'd0);
    end
    issue(MODE_ROL, 6'd4, 32'hA0000005, 0, res_v, zero_v);
    chk("post_rst_request", 64'(res_v), 64'h0000005A);

    // Randomized traffic, checked by the monitor.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] x;
      x = $urandom;
      if ($urandom_range(0, 3) == 0) x[31] = 1'b1;
      issue(2'($urandom), 6'($urandom_range(0, 63)), x,
            int'($urandom_range(0, 1)), res_v, zero_v);
    end

    // Narrow instance.
    run8(MODE_SAR, 4'd2, 8'h90, 8'hE4);
    run8(MODE_SHL, 4'd8, 8'hFF, 8'h00);
    run8(MODE_ROL, 4'd11, 8'h81, 8'h0C);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/shift_seq_unit.md
# shift_seq_unit

Parametrised, multi-cycle shift unit and successor to the combinational left shifter. Supports logical left, logical right, arithmetic right and rotate-left on a WIDTH-bit operand. Applies one log-shifter stage per clock, so a WIDTH-bit shift costs log2(WIDTH) cycles of one shared stage instead of a full barrel array. Sits behind the ALU operand mux; results return through a valid/ready output port.

## Interface
- WIDTH, 32: operand width; power of two, ≥ 4.
- LOGW, $clog2(WIDTH): derived; number of shift stages.
- SHW, LOGW+1: derived; shift-amount width, so an amount of exactly WIDTH is representable.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request (IDLE only).
- mode  in  2  0 SHL, 1 SHR (logical), 2 SAR (arithmetic), 3 ROL.
- n  in  SHW  shift amount, 0..2^SHW−1.
- in  in  WIDTH  operand.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts result.
- out  out  WIDTH  result.
- zero  out  1  out == 0; valid with out_valid.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch mode, n, in into data/amount registers; stage counter k=0; go to SHIFT.
- SHIFT:
  - Each cycle applies stage k: if n[k]=1, shift data by 2^k per mode; else pass through.
  - k increments; after stage LOGW−1, go to DONE.
- Fill rules:
  - SHL/SHR fill with 0.
  - SAR fills with the latched in[WIDTH−1].
  - ROL wraps the bits shifted out.
- Overflow (n ≥ WIDTH, i.e. any bit n[SHW−1:LOGW] set):
  - SHL/SHR: result 0.
  - SAR: result all copies of the sign bit.
  - ROL: n taken mod WIDTH; upper bits ignored.
  - Overflow is resolved at latch time by forcing the data register to the fill value. The unit still runs all LOGW stages, so latency is constant.
- DONE:
  - out_valid=1; out and zero are stable.
  - On out_ready: go to IDLE.
- n=0, or ROL with n mod WIDTH=0: out = in.
- No new request is accepted before the current result is consumed; in_valid outside IDLE is ignored.
- Mode values are only the four listed; all encodings are defined.

## Timing
- Reset (asynchronous assert, synchronous release): state=IDLE, in_ready=1, out_valid=0, out=0, zero=1, k=0.
- Reset mid-operation aborts immediately. The pending request is lost and no out_valid follows.
- Accept occurs on edge E0 where in_valid && in_ready.
  - in_ready drops after E0.
  - Stages run on edges E1..E_LOGW.
  - out_valid is high after E_LOGW: latency LOGW cycles (5 for WIDTH=32).
- Handshake:
  - Result transfers on the edge where out_valid && out_ready.
  - in_ready rises the cycle after that edge.
  - Minimum issue interval is LOGW+2 cycles with out_ready held high.
- Backpressure: out and zero must not change while out_valid=1 and out_ready=0.
- Inputs are sampled only at the accept edge. Changing in, n or mode afterwards has no effect.

## Structure
- Package shift_pkg holds:
  - mode localparams MODE_SHL=2'd0, MODE_SHR=2'd1, MODE_SAR=2'd2, MODE_ROL=2'd3;
  - FSM state encoding ST_IDLE, ST_SHIFT, ST_DONE.
- Sub-module shift_stage (combinational): inputs data, mode, stage index k, enable bit n[k], sign; output is data shifted by 2^k. shift_seq_unit instantiates it once and owns the FSM, counter and registers.

## Test plan
- WIDTH=32, in=FFFFFFFF, SHL, sweep n = 0, 1, 2, 3, 4, 15, 25, 30, 31, 32:
  - out = FFFFFFFF, FFFFFFFE, FFFFFFFC, FFFFFFF8, FFFFFFF0, FFFF8000, FE000000, C0000000, 80000000, 00000000;
  - zero=1 only for n=32;
  - each result arrives exactly 5 cycles after accept.
- SHR vs SAR, in=80000000, n=31: SHR → 00000001; SAR → FFFFFFFF. SAR with n=40 → FFFFFFFF; SHR with n=40 → 0.
- ROL, in=12345678: n=8 → 34567812; n=32 → 12345678; n=36 → 23456781.
- Backpressure:
  - hold out_ready=0 for 10 cycles after out_valid; out stays constant and in_ready stays 0;
  - in_valid pulses during SHIFT/DONE are ignored;
  - release out_ready, then in_ready=1 the next cycle.
- Reset: assert rst_n=0 during cycle 2 of SHIFT. Outputs reach reset values immediately; no out_valid after release; a new request completes normally.
- WIDTH=8 instance: SAR with in=0x90, n=2 → 0xE4, latency 3 cycles; SHL with n=8 → 0x00.
